// File: rtl/co_oc_encoder_pkg.sv
// Shared types and constants for the Cohen-Sutherland outcode front end.
package co_oc_encoder_pkg;

  localparam int POINT_W = 16;

  typedef struct packed {
    logic signed [POINT_W-1:0] x;
    logic signed [POINT_W-1:0] y;
  } point2d_t;

  localparam logic [3:0] OC_TOP    = 4'b1000;
  localparam logic [3:0] OC_BOTTOM = 4'b0100;
  localparam logic [3:0] OC_RIGHT  = 4'b0010;
  localparam logic [3:0] OC_LEFT   = 4'b0001;

  localparam logic signed [POINT_W-1:0] DEF_XMIN = 16'sd0;
  localparam logic signed [POINT_W-1:0] DEF_XMAX = 16'sd639;
  localparam logic signed [POINT_W-1:0] DEF_YMIN = 16'sd0;
  localparam logic signed [POINT_W-1:0] DEF_YMAX = 16'sd479;
  localparam int                        DEF_MAX_ITER = 4;

  function automatic logic oc_accept(input logic [3:0] oc0, input logic [3:0] oc1);
    return (oc0 | oc1) == 4'b0000;
  endfunction

  function automatic logic oc_reject(input logic [3:0] oc0, input logic [3:0] oc1);
    return (oc0 & oc1) != 4'b0000;
  endfunction

endpackage

// File: rtl/co_oc_encoder_outcode.sv
// Combinational outcode of one point against an inclusive clip rectangle.
module co_oc_encoder_outcode
  import co_oc_encoder_pkg::*;
#(
  parameter int                        COORD_W = POINT_W,
  parameter logic signed [COORD_W-1:0] XMIN    = DEF_XMIN,
  parameter logic signed [COORD_W-1:0] XMAX    = DEF_XMAX,
  parameter logic signed [COORD_W-1:0] YMIN    = DEF_YMIN,
  parameter logic signed [COORD_W-1:0] YMAX    = DEF_YMAX
) (
  input  logic signed [COORD_W-1:0] x,
  input  logic signed [COORD_W-1:0] y,
  output logic        [3:0]         oc
);

  // Points lying exactly on an edge count as inside.
  assign oc = ((y > YMAX) ? OC_TOP    : 4'b0000)
            | ((y < YMIN) ? OC_BOTTOM : 4'b0000)
            | ((x > XMAX) ? OC_RIGHT  : 4'b0000)
            | ((x < XMIN) ? OC_LEFT   : 4'b0000);

endmodule

// File: rtl/co_oc_encoder.sv
// Clip-loop front end: arbitration register (stage A) feeding an outcode register (stage B).
module co_oc_encoder
  import co_oc_encoder_pkg::*;
#(
  parameter int                        COORD_W  = POINT_W,
  parameter logic signed [COORD_W-1:0] XMIN     = DEF_XMIN,
  parameter logic signed [COORD_W-1:0] XMAX     = DEF_XMAX,
  parameter logic signed [COORD_W-1:0] YMIN     = DEF_YMIN,
  parameter logic signed [COORD_W-1:0] YMAX     = DEF_YMAX,
  parameter int                        MAX_ITER = DEF_MAX_ITER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  point2d_t   s_p0,
  input  point2d_t   s_p1,
  input  logic       r_valid,
  output logic       r_ready,
  input  point2d_t   r_p0,
  input  point2d_t   r_p1,
  input  logic [2:0] r_iter,
  output logic       m_valid,
  input  logic       m_ready,
  output point2d_t   m_p0,
  output point2d_t   m_p1,
  output logic [3:0] m_oc0,
  output logic [3:0] m_oc1,
  output logic [2:0] m_iter,
  output logic       m_accept,
  output logic       m_reject,
  output logic       busy
);

  localparam logic [2:0] MAX_ITER_L = 3'(MAX_ITER);

  logic       a_valid_q, a_valid_d;
  point2d_t   a_p0_q, a_p0_d, a_p1_q, a_p1_d;
  logic [2:0] a_iter_q, a_iter_d;

  logic       b_valid_q, b_valid_d;
  point2d_t   b_p0_q, b_p0_d, b_p1_q, b_p1_d;
  logic [3:0] b_oc0_q, b_oc0_d, b_oc1_q, b_oc1_d;
  logic [2:0] b_iter_q, b_iter_d;
  logic       b_accept_q, b_accept_d, b_reject_q, b_reject_d;

  logic       b_take_s, a_open_s;
  logic [3:0] oc0_s, oc1_s;
  logic       accept_s, reject_s;

  co_oc_encoder_outcode #(
    .COORD_W(COORD_W), .XMIN(XMIN), .XMAX(XMAX), .YMIN(YMIN), .YMAX(YMAX)
  ) u_oc0 (
    .x (a_p0_q.x),
    .y (a_p0_q.y),
    .oc(oc0_s)
  );

  co_oc_encoder_outcode #(
    .COORD_W(COORD_W), .XMIN(XMIN), .XMAX(XMAX), .YMIN(YMIN), .YMAX(YMAX)
  ) u_oc1 (
    .x (a_p1_q.x),
    .y (a_p1_q.y),
    .oc(oc1_s)
  );

  // Ready paths look only at occupancy, m_ready and r_valid so s_valid never loops back.
  assign b_take_s = a_valid_q & (~b_valid_q | m_ready);
  assign a_open_s = ~rst & (~a_valid_q | b_take_s);
  assign r_ready  = a_open_s;
  assign s_ready  = a_open_s & ~r_valid;

  assign accept_s = oc_accept(oc0_s, oc1_s);
  assign reject_s = oc_reject(oc0_s, oc1_s) | (~accept_s & (a_iter_q >= MAX_ITER_L));

  // Next-state for both pipeline stages.
  always_comb begin
    a_valid_d  = a_valid_q;
    a_p0_d     = a_p0_q;
    a_p1_d     = a_p1_q;
    a_iter_d   = a_iter_q;
    b_valid_d  = b_valid_q;
    b_p0_d     = b_p0_q;
    b_p1_d     = b_p1_q;
    b_oc0_d    = b_oc0_q;
    b_oc1_d    = b_oc1_q;
    b_iter_d   = b_iter_q;
    b_accept_d = b_accept_q;
    b_reject_d = b_reject_q;

    if (b_take_s) begin
      b_valid_d  = 1'b1;
      b_p0_d     = a_p0_q;
      b_p1_d     = a_p1_q;
      b_oc0_d    = oc0_s;
      b_oc1_d    = oc1_s;
      b_iter_d   = a_iter_q;
      b_accept_d = accept_s;
      b_reject_d = reject_s;
    end else if (m_ready) begin
      b_valid_d = 1'b0;
    end else begin
      b_valid_d = b_valid_q;
    end

    if (a_open_s) begin
      if (r_valid) begin
        a_valid_d = 1'b1;
        a_p0_d    = r_p0;
        a_p1_d    = r_p1;
        a_iter_d  = r_iter + 3'd1;
      end else if (s_valid) begin
        a_valid_d = 1'b1;
        a_p0_d    = s_p0;
        a_p1_d    = s_p1;
        a_iter_d  = 3'd0;
      end else begin
        a_valid_d = 1'b0;
      end
    end else begin
      a_valid_d = a_valid_q;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q  <= 1'b0;
      a_p0_q     <= '0;
      a_p1_q     <= '0;
      a_iter_q   <= 3'd0;
      b_valid_q  <= 1'b0;
      b_p0_q     <= '0;
      b_p1_q     <= '0;
      b_oc0_q    <= 4'b0000;
      b_oc1_q    <= 4'b0000;
      b_iter_q   <= 3'd0;
      b_accept_q <= 1'b0;
      b_reject_q <= 1'b0;
    end else begin
      a_valid_q  <= a_valid_d;
      a_p0_q     <= a_p0_d;
      a_p1_q     <= a_p1_d;
      a_iter_q   <= a_iter_d;
      b_valid_q  <= b_valid_d;
      b_p0_q     <= b_p0_d;
      b_p1_q     <= b_p1_d;
      b_oc0_q    <= b_oc0_d;
      b_oc1_q    <= b_oc1_d;
      b_iter_q   <= b_iter_d;
      b_accept_q <= b_accept_d;
      b_reject_q <= b_reject_d;
    end
  end

  assign m_valid  = b_valid_q;
  assign m_p0     = b_p0_q;
  assign m_p1     = b_p1_q;
  assign m_oc0    = b_oc0_q;
  assign m_oc1    = b_oc1_q;
  assign m_iter   = b_iter_q;
  assign m_accept = b_accept_q;
  assign m_reject = b_reject_q;
  assign busy     = a_valid_q | b_valid_q;

endmodule
